sram_rr_arbiter: RTL and testbench
==================================

// Module: sram_rr_arbiter
// PURPOSE
//  Shares one 1R1W byte-strobed SRAM macro (1-cycle registered read, en_r/en_w gated) among NREQ requesters.
//  Read and write ports are arbitrated independently, each by its own round-robin pointer.
//  Writes are posted. Reads return data on a per-requester valid/ready response channel.
//  Sits between the core-side memory clients and the SRAM instance in the testbench/SoC memory path.
// PARAMETERS
//  DW    32  data width; BW=(DW+7)/8 strobe bits
//  AW    14  word address width
//  NREQ  2   number of requesters (>=2); vectors below are packed, requester i at slice i
// PORTS
//  CLK          in   1        clock, all logic on posedge
//  RSTn         in   1        asynchronous, active-low reset
//  req_valid    in   NREQ     command valid per requester
//  req_ready    out  NREQ     command accepted this cycle (valid&ready = handshake)
//  req_wen      in   NREQ     1=write, 0=read
//  req_addr     in   NREQ*AW  word address
//  req_wdata    in   NREQ*DW  write data
//  req_wstrb    in   NREQ*BW  byte strobes (writes only)
//  rsp_valid    out  NREQ     read data valid
//  rsp_ready    in   NREQ     requester takes read data
//  rsp_data     out  NREQ*DW  read data, held stable while rsp_valid&!rsp_ready
//  sram_en_w    out  1        SRAM write enable
//  sram_addr_w  out  AW       SRAM write address
//  sram_data_w  out  DW       SRAM write data
//  sram_wstrb   out  BW       SRAM byte strobes
//  sram_en_r    out  1        SRAM read enable
//  sram_addr_r  out  AW       SRAM read address
//  sram_data_r  in   DW       SRAM read data, valid the cycle after sram_en_r
// BEHAVIOUR
//  Reset (RSTn=0, async): rsp_valid=0, rd_inflight=0, rsp_data=0, both rr pointers=NREQ-1 (requester 0 wins first).
//  Eligibility, cycle T:
//   - write-eligible(i) = req_valid[i] & req_wen[i]
//   - read-eligible(i)  = req_valid[i] & !req_wen[i] & !rd_inflight[i] & (!rsp_valid[i] | rsp_ready[i])
//  Each path grants one eligible requester, searching from pointer+1 upward with modulo-NREQ wrap.
//   Pointer <= granted index only when a grant occurs; otherwise it holds.
//  req_ready[i] = write grant(i) | read grant(i). It is combinational from req_valid/req_wen/state.
//   At most one grant per requester per cycle, because a requester issues one command type.
//  SRAM drive (combinational from grants):
//   - sram_en_w=|wgrant; addr/data/wstrb muxed from the write winner.
//   - sram_en_r=|rgrant; addr muxed from the read winner.
//   - With no grant, mux outputs are 0.
//  Writes with wstrb=0 are still granted and drive sram_en_w=1; no byte changes.
//  Read pipeline, per requester:
//   - T: grant; set rd_inflight[i].
//   - T+1: capture sram_data_r into rsp_data[i]; set rsp_valid[i]; clear rd_inflight[i].
//   - rsp_valid rises at T+2 (2-cycle read latency, grant to rsp_valid).
//   - rsp_valid[i] clears on rsp_valid&rsp_ready, unless a new capture occurs that same edge.
//   - Back-to-back reads from one requester: a new grant is allowed in the same cycle the old response is taken.
//     Sustained throughput is 1 read per 2 cycles per requester.
//  Same-cycle read and write to the same address: the read returns OLD data, because the SRAM reads before write.
//   No forwarding.
//  Read and write to different requesters in the same cycle: both granted; each path keeps its own pointer.
//  RSTn asserted mid-read: the in-flight read is dropped and no response is issued.
//   The SRAM is not reset; its contents are retained.
// TESTING
//  1) Reset: RSTn=0 then 1, all req_valid=0 -> req_ready=0, rsp_valid=0, sram_en_r=sram_en_w=0.
//  2) Req0 write addr 0x10 data 0xA5A5A5A5 strb 4'b1111, then read 0x10 -> req0 rsp_valid 2 cycles after read grant, rsp_data=0xA5A5A5A5.
//  3) Both requesters write continuously -> grants alternate 0,1,0,1 starting with 0; no requester waits more than NREQ-1 cycles.
//  4) Req0 read 0x20 with rsp_ready=0 for 5 cycles, req0 issues a second read -> second read not granted (req_ready[0]=0) until rsp taken; rsp_data stable throughout.
//  5) Req0 write 0x30 data 0x11223344 strb 4'b0101 over 0xFFFFFFFF -> read returns 0xFF22FF44.
//  6) Same cycle: req0 read 0x40 (old 0x0), req1 write 0x40 0xDEADBEEF -> req0 gets 0x0; a later read gets 0xDEADBEEF.

Source files
------------

// File: rtl/sram_rr_arbiter_if.sv
// Requester and SRAM-side bus of sram_rr_arbiter.
// Command and response vectors are packed, with requester i at slice i.
// master: the requesters plus the SRAM macro (the environment).
// slave: the arbiter.
interface sram_rr_arbiter_if #(
  parameter int DW   = 32,
  parameter int AW   = 14,
  parameter int NREQ = 2
);
  localparam int BW = (DW + 7) / 8;

  // Requester command channel
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_wen;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ*BW-1:0] req_wstrb;

  // Read response channel
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [NREQ*DW-1:0] rsp_data;

  // 1R1W SRAM macro
  logic               sram_en_w;
  logic [AW-1:0]      sram_addr_w;
  logic [DW-1:0]      sram_data_w;
  logic [BW-1:0]      sram_wstrb;
  logic               sram_en_r;
  logic [AW-1:0]      sram_addr_r;
  logic [DW-1:0]      sram_data_r;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready, sram_data_r,
    input  req_ready, rsp_valid, rsp_data,
    input  sram_en_w, sram_addr_w, sram_data_w, sram_wstrb, sram_en_r, sram_addr_r
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready, sram_data_r,
    output req_ready, rsp_valid, rsp_data,
    output sram_en_w, sram_addr_w, sram_data_w, sram_wstrb, sram_en_r, sram_addr_r
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter that shares one 1R1W byte-strobed SRAM among NREQ requesters.
// The read and write ports are arbitrated independently, each with its own pointer.
// Writes are posted. Reads return through a per-requester valid/ready response
// register, two cycles after the grant.
module sram_rr_arbiter #(
  parameter int DW   = 32,
  parameter int AW   = 14,
  parameter int NREQ = 2
) (
  input logic             CLK,
  input logic             RSTn,
  sram_rr_arbiter_if.slave bus
);
  localparam int BW = (DW + 7) / 8;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [IW-1:0] idx_t;

  // Both pointers start at the top requester, so requester 0 wins the first contest.
  localparam idx_t PTR_RST = idx_t'(NREQ - 1);

  idx_t            wr_ptr, rd_ptr;
  idx_t            wr_idx, rd_idx;
  logic [NREQ-1:0] wr_elig, rd_elig;
  logic [NREQ-1:0] wr_gnt, rd_gnt;
  logic [NREQ-1:0] rd_inflight;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_data_q [NREQ];

  // First eligible index after ptr, wrapping modulo NREQ. The result is only
  // used when at least one requester is eligible.
  function automatic idx_t rr_pick(input logic [NREQ-1:0] elig, input idx_t ptr);
    idx_t pick;
    idx_t cand;
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = idx_t'((int'(ptr) + k) % NREQ);
      if (!found && elig[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Compute eligibility and pick the round-robin winner on each port.
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that leaves
    // a signal unassigned would infer a latch.
    wr_gnt  = '0;
    rd_gnt  = '0;
    wr_elig = bus.req_valid & bus.req_wen;
    // A requester may read again only once the previous response is gone,
    // or is being taken this cycle.
    rd_elig = bus.req_valid & ~bus.req_wen & ~rd_inflight & (~rsp_valid_q | bus.rsp_ready);
    wr_idx  = rr_pick(wr_elig, wr_ptr);
    rd_idx  = rr_pick(rd_elig, rd_ptr);
    if (|wr_elig) wr_gnt[wr_idx] = 1'b1;
    if (|rd_elig) rd_gnt[rd_idx] = 1'b1;
  end

  // A requester issues one command type at a time, so it gets at most one grant.
  assign bus.req_ready = wr_gnt | rd_gnt;

  // Drive the SRAM ports from the winners. The muxes output zero when the port is idle.
  always_comb begin
    bus.sram_en_w   = |wr_elig;
    bus.sram_addr_w = '0;
    bus.sram_data_w = '0;
    bus.sram_wstrb  = '0;
    bus.sram_en_r   = |rd_elig;
    bus.sram_addr_r = '0;
    if (|wr_elig) begin
      bus.sram_addr_w = bus.req_addr [wr_idx*AW +: AW];
      bus.sram_data_w = bus.req_wdata[wr_idx*DW +: DW];
      bus.sram_wstrb  = bus.req_wstrb[wr_idx*BW +: BW];
    end
    if (|rd_elig) begin
      bus.sram_addr_r = bus.req_addr[rd_idx*AW +: AW];
    end
  end

  // Advance each round-robin pointer to its winner; hold it when that port is idle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= PTR_RST;
      rd_ptr <= PTR_RST;
    end else begin
      // NOTE: sequential state uses non-blocking assignment only, so every
      // flop samples pre-edge values regardless of statement order.
      if (|wr_elig) wr_ptr <= wr_idx;
      if (|rd_elig) rd_ptr <= rd_idx;
    end
  end

  // Read pipeline. A grant marks the read in flight. The next edge captures
  // the SRAM output into the response register and raises rsp_valid.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_inflight <= '0;
      rsp_valid_q <= '0;
      // NOTE: rsp_data_q is a small register array, not a memory macro, so it
      // takes its reset value directly. The SRAM contents are never reset.
      for (int i = 0; i < NREQ; i++) rsp_data_q[i] <= '0;
    end else begin
      // A requester is read-eligible only when nothing is in flight, so a
      // grant and a capture never collide.
      rd_inflight <= rd_gnt;
      for (int i = 0; i < NREQ; i++) begin
        if (rd_inflight[i]) begin
          rsp_data_q[i]  <= bus.sram_data_r;
          rsp_valid_q[i] <= 1'b1;
        end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_rsp
    assign bus.rsp_data[g*DW +: DW] = rsp_data_q[g];
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural 1R1W SRAM.
// Expected read data is pushed into a per-requester queue when each read is
// granted. A monitor pops an entry and compares it on every response handshake.
module tb_sram_rr_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 14;
  localparam int NREQ = 2;
  localparam int BW   = (DW + 7) / 8;

  logic CLK;
  logic RSTn;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  sram_rr_arbiter_if #(.DW(DW), .AW(AW), .NREQ(NREQ)) bus ();

  sram_rr_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural SRAM: registered read, byte-strobed write. The old word is
  // read before a write to the same address lands.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (bus.sram_en_r) bus.sram_data_r <= mem[bus.sram_addr_r];
    if (bus.sram_en_w)
      for (int b = 0; b < BW; b++)
        if (bus.sram_wstrb[b]) mem[bus.sram_addr_w][b*8 +: 8] <= bus.sram_data_w[b*8 +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: compare every response that completes a handshake.
  always @(negedge CLK) begin
    if (RSTn) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.rsp_valid[i] === 1'b1 && bus.rsp_ready[i] === 1'b1) begin
          if (i == 0 && exp_q0.size() > 0)      check("rsp_data0", bus.rsp_data[0 +: DW], exp_q0.pop_front());
          else if (i == 1 && exp_q1.size() > 0) check("rsp_data1", bus.rsp_data[DW +: DW], exp_q1.pop_front());
          else check("unexpected_rsp", 32'(i), 32'hFFFF_FFFF);
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic [DW-1:0] d);
    if (i == 0) exp_q0.push_back(d);
    else        exp_q1.push_back(d);
  endtask

  // Issue one command from requester i and wait, with a bound, for its grant.
  task automatic issue(input int i, input logic wen, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [BW-1:0] strb,
                       input logic [DW-1:0] exp_rd, input bit expect_rsp);
    bit got;
    got = 1'b0;
    bus.req_wen[i]             = wen;
    bus.req_addr [i*AW +: AW]  = addr;
    bus.req_wdata[i*DW +: DW]  = data;
    bus.req_wstrb[i*BW +: BW]  = strb;
    bus.req_valid[i]           = 1'b1;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge CLK);
      if (bus.req_ready[i] === 1'b1) got = 1'b1;
    end
    check("grant", 32'(got), 32'd1);
    if (got) begin
      if (wen) begin
        check("en_w", 32'(bus.sram_en_w), 32'd1);
        check("addr_w", 32'(bus.sram_addr_w), 32'(addr));
      end else begin
        check("en_r", 32'(bus.sram_en_r), 32'd1);
        check("addr_r", 32'(bus.sram_addr_r), 32'(addr));
        if (expect_rsp) push_exp(i, exp_rd);
      end
    end
    @(posedge CLK); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  initial begin
    RSTn          = 1'b0;
    bus.req_valid = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = '1;

    // 1) Reset values, during reset and after release.
    @(negedge CLK);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data[0 +: DW], 32'd0);
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
    check("idle_req_ready", 32'(bus.req_ready), 32'd0);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_en_r", 32'(bus.sram_en_r), 32'd0);
    check("idle_en_w", 32'(bus.sram_en_w), 32'd0);
    @(posedge CLK); #1;

    // 2) Write then read back. rsp_valid is low one cycle after the grant
    //    and high two cycles after it.
    issue(0, 1'b1, 14'h10, 32'hA5A5_A5A5, 4'hF, '0, 1'b0);
    issue(0, 1'b0, 14'h10, '0, '0, 32'hA5A5_A5A5, 1'b1);
    @(negedge CLK);
    check("lat_t1_rsp_valid", 32'(bus.rsp_valid[0]), 32'd0);
    @(negedge CLK);
    check("lat_t2_rsp_valid", 32'(bus.rsp_valid[0]), 32'd1);
    @(posedge CLK); #1;

    // 5) Partial-strobe write over all-ones.
    issue(0, 1'b1, 14'h30, 32'hFFFF_FFFF, 4'hF, '0, 1'b0);
    issue(0, 1'b1, 14'h30, 32'h1122_3344, 4'b0101, '0, 1'b0);
    issue(0, 1'b0, 14'h30, '0, '0, 32'hFF22_FF44, 1'b1);
    repeat (3) @(posedge CLK); #1;

    // 4) The response is held off. A second read is blocked and rsp_data stays
    //    stable until the first response is taken.
    issue(0, 1'b1, 14'h20, 32'hCAFE_F00D, 4'hF, '0, 1'b0);
    bus.rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 14'h20, '0, '0, 32'hCAFE_F00D, 1'b1);
    bus.req_wen[0]              = 1'b0;
    bus.req_addr[0 +: AW]       = 14'h10;
    bus.req_valid[0]            = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      check("stall_req_ready", 32'(bus.req_ready[0]), 32'd0);
      check("stall_rsp_valid", 32'(bus.rsp_valid[0]), (c == 0) ? 32'd0 : 32'd1);
      if (c > 0) check("stall_rsp_data", bus.rsp_data[0 +: DW], 32'hCAFE_F00D);
      @(posedge CLK); #1;
    end
    bus.rsp_ready[0] = 1'b1;
    @(negedge CLK);
    check("take_and_regrant", 32'(bus.req_ready[0]), 32'd1);
    if (bus.req_ready[0] === 1'b1) push_exp(0, 32'hA5A5_A5A5);
    @(posedge CLK); #1;
    bus.req_valid[0] = 1'b0;
    repeat (3) @(posedge CLK); #1;

    // 6) A same-cycle read and write to one address returns the old data.
    issue(0, 1'b1, 14'h40, 32'h0, 4'hF, '0, 1'b0);
    bus.req_wen               = 2'b10;
    bus.req_addr[0 +: AW]     = 14'h40;
    bus.req_addr[AW +: AW]    = 14'h40;
    bus.req_wdata[DW +: DW]   = 32'hDEAD_BEEF;
    bus.req_wstrb[BW +: BW]   = 4'hF;
    bus.req_valid             = 2'b11;
    @(negedge CLK);
    check("rw_same_cycle_ready", 32'(bus.req_ready), 32'd3);
    if (bus.req_ready[0] === 1'b1) push_exp(0, 32'h0);
    @(posedge CLK); #1;
    bus.req_valid = 2'b00;
    issue(0, 1'b0, 14'h40, '0, '0, 32'hDEAD_BEEF, 1'b1);
    repeat (3) @(posedge CLK); #1;

    // A zero-strobe write is still granted and changes no byte.
    issue(1, 1'b1, 14'h10, 32'h0, 4'h0, '0, 1'b0);
    issue(1, 1'b0, 14'h10, '0, '0, 32'hA5A5_A5A5, 1'b1);
    repeat (3) @(posedge CLK); #1;

    // Reset mid-read drops the read. The SRAM keeps its contents.
    issue(0, 1'b0, 14'h10, '0, '0, '0, 1'b0);
    #2 RSTn = 1'b0;
    @(negedge CLK);
    check("rst_drop_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge CLK); #1 RSTn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge CLK); #1;

    // 3) Fresh pointers: continuous writes from both requesters alternate 0,1,0,1...
    do_reset();
    bus.req_wen               = 2'b11;
    bus.req_addr[0 +: AW]     = 14'h100;
    bus.req_addr[AW +: AW]    = 14'h101;
    bus.req_wdata[0 +: DW]    = 32'h0000_0100;
    bus.req_wdata[DW +: DW]   = 32'h0000_0101;
    bus.req_wstrb             = '1;
    bus.req_valid             = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check("rr_wr_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      check("rr_wr_addr", 32'(bus.sram_addr_w), (k % 2 == 0) ? 32'h100 : 32'h101);
      @(posedge CLK); #1;
    end
    bus.req_valid = 2'b00;
    issue(0, 1'b0, 14'h100, '0, '0, 32'h0000_0100, 1'b1);
    issue(1, 1'b0, 14'h101, '0, '0, 32'h0000_0101, 1'b1);
    issue(1, 1'b0, 14'h10,  '0, '0, 32'hA5A5_A5A5, 1'b1);

    // Drain the scoreboard, with a bound.
    for (int c = 0; c < 50 && (exp_q0.size() + exp_q1.size()) != 0; c++) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
